// File: rtl/pkt_hdr_loader.sv
// ---------------------------------------------------------------------------
// pkt_hdr_loader
//
// Loads packet-header words from the PHU beat stream into a banked header
// RAM. The consumer reads out_phu_active_bank while the next update fills
// bank (active_bank + 1). The bank only flips once a complete,
// non-overflowed update has landed, so a bad or partial update never
// disturbs what the consumer sees.
//
// Beat stream: each beat is one in_phu_data word tagged in [133:132]
// (01 head, 11 middle, 10 tail). After the head beat come the md1 beat,
// SKIP_NUM encapsulated-metadata beats that are dropped, and then the header
// words. The tail beat is itself a header word.
//
// Optional feature: define PKT_HDR_LOADER_STAT_EN to build the saturating
// good/error statistics counters. Without it both counters are tied to 0.
//
// Handshake: a beat is transferred on every rising clk edge where
// in_phu_data_wr is 1. There is no back-pressure, so the block accepts every
// valid beat. out_phu_pkt_hdr_wr is a one-cycle write strobe that qualifies
// out_phu_pkt_hdr_addr / out_phu_pkt_hdr.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   in_phu_data[133:0]       tagged beat: [133:132] type, [127:0] payload
//   in_phu_data_wr           beat valid
//   i_lau_update_finish      1 allows new updates, 0 clears the finish flag
//   out_phu_pkt_hdr_wr       header RAM write strobe
//   out_phu_pkt_hdr_addr     header RAM address {bank, offset}
//   out_phu_pkt_hdr          header RAM write data
//   out_phu_pkt_hdr_seq      sequence number of the last good update
//   out_phu_active_bank      bank the consumer reads
//   out_phu_hdr_cnt          word count of the last good update
//   out_phu_update_finish    sticky "good update done" flag
//   out_phu_err              one-cycle pulse on an aborted/overflowed update
//   out_phu_good_cnt         good-update counter (statistics)
//   out_phu_err_cnt          error-pulse counter (statistics)
//   dbg_state                current FSM state, for observation
// ---------------------------------------------------------------------------
module pkt_hdr_loader #(
   parameter int          DATA_W      = 128,
   parameter int          ADDR_W      = 6,
   parameter int          BANK_W      = 1,
   parameter int          SKIP_NUM    = 2,
   parameter logic [15:0] TYPE_VAL    = 16'hff01,
   parameter logic [3:0]  SUBTYPE_VAL = 4'h1,
   localparam int         OFFSET_W    = ADDR_W - BANK_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [133:0]        in_phu_data,
   input  logic                in_phu_data_wr,
   input  logic                i_lau_update_finish,
   output logic                out_phu_pkt_hdr_wr,
   output logic [ADDR_W-1:0]   out_phu_pkt_hdr_addr,
   output logic [DATA_W-1:0]   out_phu_pkt_hdr,
   output logic [7:0]          out_phu_pkt_hdr_seq,
   output logic [BANK_W-1:0]   out_phu_active_bank,
   output logic [OFFSET_W:0]   out_phu_hdr_cnt,
   output logic                out_phu_update_finish,
   output logic                out_phu_err,
   output logic [15:0]         out_phu_good_cnt,
   output logic [15:0]         out_phu_err_cnt,
   output logic [2:0]          dbg_state
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_MD1     = 3'd1,
      ST_SKIP    = 3'd2,
      ST_LOAD    = 3'd3,
      ST_DISCARD = 3'd4
   } state_t;

   // Word count that means "bank full": one past the last offset.
   localparam logic [OFFSET_W:0] WORDS     = {1'b1, {OFFSET_W{1'b0}}};
   localparam logic [3:0]        SKIP_LAST = 4'((SKIP_NUM == 0) ? 0 : SKIP_NUM - 1);

   state_t              state;
   logic [3:0]          skip_cnt;
   logic [OFFSET_W:0]   word_cnt;   // words written so far in this update
   logic                ovf;        // a word was dropped for lack of room
   logic [7:0]          pend_seq;

   logic                is_head;
   logic                is_tail;
   logic                md1_match;
   logic                room;
   logic                err_ev;
   logic                good_ev;
   logic [BANK_W-1:0]   wr_bank;

   // Only the tag and payload are meaningful; the rest is reserved.
   logic unused_bits;
   assign unused_bits = &{1'b0, in_phu_data};

   assign is_head   = (in_phu_data[133:132] == 2'b01);
   assign is_tail   = (in_phu_data[133:132] == 2'b10);
   assign md1_match = (in_phu_data[31:16] == TYPE_VAL) &&
                      (in_phu_data[15:12] == SUBTYPE_VAL);
   assign room      = (word_cnt != WORDS);
   assign wr_bank   = out_phu_active_bank + BANK_W'(1);
   assign dbg_state = state;

   // Update outcome of the beat being accepted this cycle.
   always_comb begin
      err_ev  = 1'b0;
      good_ev = 1'b0;
      if (in_phu_data_wr && state != ST_IDLE) begin
         if (is_head) begin
            err_ev = 1'b1;                 // new packet cuts the old one short
         end else if (is_tail) begin
            case (state)
               ST_MD1, ST_SKIP: err_ev = 1'b1;   // truncated packet
               ST_LOAD: begin
                  // The tail is a word too: it overflows if no room is left.
                  if (ovf || !room) err_ev  = 1'b1;
                  else              good_ev = 1'b1;
               end
               default: ;                  // DISCARD ends silently
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state                 <= ST_IDLE;
         skip_cnt              <= '0;
         word_cnt              <= '0;
         ovf                   <= 1'b0;
         pend_seq              <= '0;
         out_phu_pkt_hdr_wr    <= 1'b0;
         out_phu_pkt_hdr_addr  <= '0;
         out_phu_pkt_hdr       <= '0;
         out_phu_pkt_hdr_seq   <= '0;
         out_phu_active_bank   <= '0;
         out_phu_hdr_cnt       <= '0;
         out_phu_update_finish <= 1'b0;
         out_phu_err           <= 1'b0;
      end else begin
         out_phu_pkt_hdr_wr <= 1'b0;
         out_phu_err        <= err_ev;

         // Set wins over the consumer's clear on the same cycle.
         if (good_ev)                   out_phu_update_finish <= 1'b1;
         else if (!i_lau_update_finish) out_phu_update_finish <= 1'b0;

         if (in_phu_data_wr) begin
            if (is_head && state != ST_IDLE) begin
               state <= i_lau_update_finish ? ST_MD1 : ST_IDLE;
            end else begin
               case (state)
                  ST_IDLE: begin
                     if (is_head && i_lau_update_finish) state <= ST_MD1;
                  end
                  ST_MD1: begin
                     if (is_tail) begin
                        state <= ST_IDLE;
                     end else if (md1_match) begin
                        pend_seq <= in_phu_data[7:0];
                        skip_cnt <= '0;
                        word_cnt <= '0;
                        ovf      <= 1'b0;
                        state    <= (SKIP_NUM == 0) ? ST_LOAD : ST_SKIP;
                     end else begin
                        state <= ST_DISCARD;
                     end
                  end
                  ST_SKIP: begin
                     if (is_tail)                    state <= ST_IDLE;
                     else if (skip_cnt == SKIP_LAST) state <= ST_LOAD;
                     else                            skip_cnt <= skip_cnt + 4'd1;
                  end
                  ST_LOAD: begin
                     if (room) begin
                        out_phu_pkt_hdr_wr   <= 1'b1;
                        out_phu_pkt_hdr_addr <= {wr_bank, word_cnt[OFFSET_W-1:0]};
                        out_phu_pkt_hdr      <= in_phu_data[DATA_W-1:0];
                        word_cnt             <= word_cnt + (OFFSET_W+1)'(1);
                     end else begin
                        ovf <= 1'b1;         // offset holds; never wraps
                     end
                     if (is_tail) begin
                        state <= ST_IDLE;
                        if (good_ev) begin
                           out_phu_active_bank <= wr_bank;
                           out_phu_pkt_hdr_seq <= pend_seq;
                           out_phu_hdr_cnt     <= word_cnt + (OFFSET_W+1)'(1);
                        end
                     end
                  end
                  ST_DISCARD: begin
                     if (is_tail) state <= ST_IDLE;
                  end
                  default: state <= ST_IDLE;
               endcase
            end
         end
      end
   end

`ifdef PKT_HDR_LOADER_STAT_EN
   // Saturating statistics, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_phu_good_cnt <= '0;
         out_phu_err_cnt  <= '0;
      end else begin
         if (good_ev && out_phu_good_cnt != 16'hffff)
            out_phu_good_cnt <= out_phu_good_cnt + 16'd1;
         if (err_ev && out_phu_err_cnt != 16'hffff)
            out_phu_err_cnt <= out_phu_err_cnt + 16'd1;
      end
   end
`else
   assign out_phu_good_cnt = 16'd0;
   assign out_phu_err_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_pkt_hdr_loader.sv
module tb_pkt_hdr_loader;
  localparam int DATA_W   = 128;
  localparam int ADDR_W   = 6;
  localparam int BANK_W   = 1;
  localparam int OFFSET_W = ADDR_W - BANK_W;
  localparam int SKIP_NUM = 2;
  localparam int WORDS    = 1 << OFFSET_W;
  localparam logic [1:0] K_HEAD = 2'b01, K_MID = 2'b11, K_TAIL = 2'b10;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [133:0]        in_phu_data;
  logic                in_phu_data_wr;
  logic                i_lau_update_finish;
  logic                out_phu_pkt_hdr_wr;
  logic [ADDR_W-1:0]   out_phu_pkt_hdr_addr;
  logic [DATA_W-1:0]   out_phu_pkt_hdr;
  logic [7:0]          out_phu_pkt_hdr_seq;
  logic [BANK_W-1:0]   out_phu_active_bank;
  logic [OFFSET_W:0]   out_phu_hdr_cnt;
  logic                out_phu_update_finish;
  logic                out_phu_err;
  logic [15:0]         out_phu_good_cnt;
  logic [15:0]         out_phu_err_cnt;
  logic [2:0]          dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  pkt_hdr_loader dut (
    .clk(clk), .rst_n(rst_n),
    .in_phu_data(in_phu_data), .in_phu_data_wr(in_phu_data_wr),
    .i_lau_update_finish(i_lau_update_finish),
    .out_phu_pkt_hdr_wr(out_phu_pkt_hdr_wr),
    .out_phu_pkt_hdr_addr(out_phu_pkt_hdr_addr),
    .out_phu_pkt_hdr(out_phu_pkt_hdr),
    .out_phu_pkt_hdr_seq(out_phu_pkt_hdr_seq),
    .out_phu_active_bank(out_phu_active_bank),
    .out_phu_hdr_cnt(out_phu_hdr_cnt),
    .out_phu_update_finish(out_phu_update_finish),
    .out_phu_err(out_phu_err),
    .out_phu_good_cnt(out_phu_good_cnt),
    .out_phu_err_cnt(out_phu_err_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- reference model state ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [BANK_W-1:0] m_bank;
  logic [7:0]        m_seq;
  int                m_cnt;
  bit                m_finish;
  int                m_good;     // statistics counters since last reset
  int                m_errs;
  int                exp_pulses; // err pulses over the whole run
  int                obs_pulses = 0;
  int                exp_good_stat, exp_err_stat;

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] md1(input logic [15:0] t, input logic [7:0] sq);
    logic [127:0] d;
    d = rnd128();
    d[31:16] = t;
    d[15:12] = 4'h1;
    d[7:0]   = sq;
    return d;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (out_phu_err === 1'b1) obs_pulses++;
    if (out_phu_pkt_hdr_wr === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write",
                 out_phu_pkt_hdr_addr, out_phu_pkt_hdr);
      end else begin
        logic [ADDR_W+DATA_W-1:0] e;
        e = exp_q.pop_front();
        if ({out_phu_pkt_hdr_addr, out_phu_pkt_hdr} !== e) begin
          n_fail++;
          $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                   out_phu_pkt_hdr_addr, out_phu_pkt_hdr,
                   e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input logic [1:0] kind, input logic [127:0] pay, input int max_gap);
    int gap;
    gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
    repeat (gap) @(negedge clk);
    in_phu_data    = {kind, 4'h0, pay};
    in_phu_data_wr = 1'b1;
    @(negedge clk);
    in_phu_data_wr = 1'b0;
    in_phu_data    = {K_HEAD, 4'h0, rnd128()};  // junk while not valid
  endtask

  // Whole packet; the model outcome follows from the packet's shape alone.
  task automatic send_pkt(input bit good_type, input int n_words,
                          input logic [7:0] sq, input int max_gap);
    logic [127:0] d;
    logic [BANK_W-1:0] wb;
    logic [OFFSET_W-1:0] off;
    wb = m_bank + 1'b1;
    drive_beat(K_HEAD, rnd128(), max_gap);
    drive_beat(K_MID, md1(good_type ? 16'hff01 : 16'hff02, sq), max_gap);
    for (int i = 0; i < SKIP_NUM; i++) drive_beat(K_MID, rnd128(), max_gap);
    for (int i = 0; i < n_words; i++) begin
      d = rnd128();
      off = i[OFFSET_W-1:0];
      if (good_type && i < WORDS) exp_q.push_back({wb, off, d});
      drive_beat((i == n_words - 1) ? K_TAIL : K_MID, d, max_gap);
    end
    if (good_type) begin
      if (n_words <= WORDS) begin
        m_bank = wb; m_seq = sq; m_cnt = n_words; m_finish = 1'b1; m_good++;
      end else begin
        m_errs++; exp_pulses++;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_phu_data_wr = 1'b0; i_lau_update_finish = 1'b0;
    in_phu_data = '0;
    m_bank = '0; m_seq = '0; m_cnt = 0; m_finish = 1'b0;
    m_good = 0; m_errs = 0; exp_pulses = 0;
    repeat (3) @(negedge clk);
    n_cmp++; if (out_phu_pkt_hdr_wr !== 1'b0) begin n_fail++; $display("FAIL rst_wr: got %b, required 0", out_phu_pkt_hdr_wr); end
    n_cmp++; if (out_phu_active_bank !== '0) begin n_fail++; $display("FAIL rst_bank: got %0d, required 0", out_phu_active_bank); end
    n_cmp++; if (out_phu_pkt_hdr_seq !== 8'd0) begin n_fail++; $display("FAIL rst_seq: got %0d, required 0", out_phu_pkt_hdr_seq); end
    n_cmp++; if (out_phu_hdr_cnt !== '0) begin n_fail++; $display("FAIL rst_cnt: got %0d, required 0", out_phu_hdr_cnt); end
    n_cmp++; if (out_phu_update_finish !== 1'b0 || out_phu_err !== 1'b0) begin n_fail++; $display("FAIL rst_flags: got finish=%b err=%b, required 0 0", out_phu_update_finish, out_phu_err); end
    n_cmp++; if (out_phu_good_cnt !== 16'd0 || out_phu_err_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_stats: got %0d %0d, required 0 0", out_phu_good_cnt, out_phu_err_cnt); end
    n_cmp++; if (out_phu_pkt_hdr_addr !== '0 || out_phu_pkt_hdr !== '0) begin n_fail++; $display("FAIL rst_wport: got addr=%0d data=%h, required 0", out_phu_pkt_hdr_addr, out_phu_pkt_hdr); end
    rst_n = 1'b1;
    i_lau_update_finish = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_good();
    send_pkt(1'b1, 4, 8'h5A, 0);
    n_cmp++; if (out_phu_active_bank !== 1'b1) begin n_fail++; $display("FAIL good_bank: got %0d, required 1", out_phu_active_bank); end
    n_cmp++; if (out_phu_pkt_hdr_seq !== 8'h5A) begin n_fail++; $display("FAIL good_seq: got %h, required 5a", out_phu_pkt_hdr_seq); end
    n_cmp++; if (out_phu_hdr_cnt !== 6'd4) begin n_fail++; $display("FAIL good_cnt: got %0d, required 4", out_phu_hdr_cnt); end
    n_cmp++; if (out_phu_update_finish !== 1'b1) begin n_fail++; $display("FAIL good_finish: got %b, required 1", out_phu_update_finish); end
  endtask

  task automatic test_gaps();
    send_pkt(1'b1, 1, 8'h07, 3);
    n_cmp++; if (out_phu_active_bank !== 1'b0) begin n_fail++; $display("FAIL gaps_bank: got %0d, required 0", out_phu_active_bank); end
    n_cmp++; if (out_phu_pkt_hdr_seq !== 8'h07 || out_phu_hdr_cnt !== 6'd1) begin n_fail++; $display("FAIL gaps_seq_cnt: got %h/%0d, required 07/1", out_phu_pkt_hdr_seq, out_phu_hdr_cnt); end
  endtask

  task automatic test_bad_type();
    send_pkt(1'b0, 3, 8'h99, 1);
    n_cmp++; if (out_phu_active_bank !== m_bank || out_phu_pkt_hdr_seq !== m_seq) begin n_fail++; $display("FAIL badtype_keep: got bank=%0d seq=%h, required %0d %h", out_phu_active_bank, out_phu_pkt_hdr_seq, m_bank, m_seq); end
    n_cmp++; if (obs_pulses !== exp_pulses) begin n_fail++; $display("FAIL badtype_err: got %0d pulses, required %0d", obs_pulses, exp_pulses); end
  endtask

  task automatic test_overflow();
    send_pkt(1'b1, WORDS + 1, 8'hC3, 0);
    n_cmp++; if (obs_pulses !== exp_pulses) begin n_fail++; $display("FAIL ovf_err: got %0d pulses, required %0d", obs_pulses, exp_pulses); end
    n_cmp++; if (out_phu_active_bank !== m_bank || out_phu_hdr_cnt !== 6'(m_cnt)) begin n_fail++; $display("FAIL ovf_keep: got bank=%0d cnt=%0d, required %0d %0d", out_phu_active_bank, out_phu_hdr_cnt, m_bank, m_cnt); end
    n_cmp++; if (out_phu_update_finish !== m_finish || out_phu_pkt_hdr_seq !== m_seq) begin n_fail++; $display("FAIL ovf_flags: got finish=%b seq=%h, required %b %h", out_phu_update_finish, out_phu_pkt_hdr_seq, m_finish, m_seq); end
  endtask

  task automatic test_head_in_load();
    logic [127:0] d;
    logic [BANK_W-1:0] wb;
    wb = m_bank + 1'b1;
    drive_beat(K_HEAD, rnd128(), 0);
    drive_beat(K_MID, md1(16'hff01, 8'h33), 0);
    for (int i = 0; i < SKIP_NUM; i++) drive_beat(K_MID, rnd128(), 0);
    for (int i = 0; i < 2; i++) begin
      d = rnd128(); exp_q.push_back({wb, 5'(i), d}); drive_beat(K_MID, d, 0);
    end
    drive_beat(K_HEAD, rnd128(), 0);   // aborts; restarts at md1
    m_errs++; exp_pulses++;
    drive_beat(K_MID, md1(16'hff01, 8'h44), 0);
    for (int i = 0; i < SKIP_NUM; i++) drive_beat(K_MID, rnd128(), 0);
    for (int i = 0; i < 3; i++) begin
      d = rnd128(); exp_q.push_back({wb, 5'(i), d});
      drive_beat((i == 2) ? K_TAIL : K_MID, d, 0);
    end
    m_bank = wb; m_seq = 8'h44; m_cnt = 3; m_finish = 1'b1; m_good++;
    repeat (2) @(negedge clk);
    n_cmp++; if (obs_pulses !== exp_pulses) begin n_fail++; $display("FAIL hil_err: got %0d pulses, required %0d", obs_pulses, exp_pulses); end
    n_cmp++; if (out_phu_active_bank !== m_bank || out_phu_pkt_hdr_seq !== 8'h44 || out_phu_hdr_cnt !== 6'd3) begin n_fail++; $display("FAIL hil_result: got bank=%0d seq=%h cnt=%0d, required %0d 44 3", out_phu_active_bank, out_phu_pkt_hdr_seq, out_phu_hdr_cnt, m_bank); end
  endtask

  task automatic test_lau();
    i_lau_update_finish = 1'b0;
    m_finish = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (out_phu_update_finish !== 1'b0) begin n_fail++; $display("FAIL lau_clear: got %b, required 0", out_phu_update_finish); end
    drive_beat(K_HEAD, rnd128(), 0);
    drive_beat(K_MID, md1(16'hff01, 8'hEE), 0);
    for (int i = 0; i < SKIP_NUM + 1; i++) drive_beat(K_MID, rnd128(), 0);
    drive_beat(K_TAIL, rnd128(), 0);
    repeat (2) @(negedge clk);
    n_cmp++; if (out_phu_active_bank !== m_bank || out_phu_pkt_hdr_seq !== m_seq || out_phu_update_finish !== 1'b0) begin n_fail++; $display("FAIL lau_ignore: got bank=%0d seq=%h finish=%b, required %0d %h 0", out_phu_active_bank, out_phu_pkt_hdr_seq, out_phu_update_finish, m_bank, m_seq); end
    i_lau_update_finish = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_truncated();
    drive_beat(K_HEAD, rnd128(), 0);
    drive_beat(K_TAIL, rnd128(), 0);                 // tail in MD1
    drive_beat(K_HEAD, rnd128(), 0);
    drive_beat(K_MID, md1(16'hff01, 8'h12), 0);
    drive_beat(K_TAIL, rnd128(), 0);                 // tail in SKIP
    m_errs += 2; exp_pulses += 2;
    repeat (2) @(negedge clk);
    n_cmp++; if (obs_pulses !== exp_pulses) begin n_fail++; $display("FAIL trunc_err: got %0d pulses, required %0d", obs_pulses, exp_pulses); end
    n_cmp++; if (out_phu_active_bank !== m_bank || out_phu_pkt_hdr_seq !== m_seq) begin n_fail++; $display("FAIL trunc_keep: got bank=%0d seq=%h, required %0d %h", out_phu_active_bank, out_phu_pkt_hdr_seq, m_bank, m_seq); end
  endtask

  task automatic test_random();
    int kind, n;
    logic [7:0] sq;
    for (int p = 0; p < 14; p++) begin
      kind = $urandom_range(9, 0);
      sq = 8'($urandom);
      if (kind < 6)      send_pkt(1'b1, $urandom_range(8, 1), sq, 2);
      else if (kind < 8) send_pkt(1'b0, $urandom_range(4, 1), sq, 2);
      else begin n = $urandom_range(WORDS + 2, WORDS - 1); send_pkt(1'b1, n, sq, 1); end
      n_cmp++; if (out_phu_active_bank !== m_bank || out_phu_pkt_hdr_seq !== m_seq || out_phu_hdr_cnt !== 6'(m_cnt) || out_phu_update_finish !== m_finish) begin n_fail++; $display("FAIL rand_%0d: got bank=%0d seq=%h cnt=%0d finish=%b, required %0d %h %0d %b", p, out_phu_active_bank, out_phu_pkt_hdr_seq, out_phu_hdr_cnt, out_phu_update_finish, m_bank, m_seq, m_cnt, m_finish); end
      n_cmp++; if (obs_pulses !== exp_pulses) begin n_fail++; $display("FAIL rand_err_%0d: got %0d pulses, required %0d", p, obs_pulses, exp_pulses); end
    end
  endtask

  task automatic test_stats();
`ifdef PKT_HDR_LOADER_STAT_EN
    exp_good_stat = m_good; exp_err_stat = m_errs;
`else
    exp_good_stat = 0; exp_err_stat = 0;
`endif
    n_cmp++; if (out_phu_good_cnt !== 16'(exp_good_stat) || out_phu_err_cnt !== 16'(exp_err_stat)) begin n_fail++; $display("FAIL stats: got good=%0d err=%0d, required %0d %0d", out_phu_good_cnt, out_phu_err_cnt, exp_good_stat, exp_err_stat); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] d;
    logic [BANK_W-1:0] wb;
    wb = m_bank + 1'b1;
    drive_beat(K_HEAD, rnd128(), 0);
    drive_beat(K_MID, md1(16'hff01, 8'h21), 0);
    for (int i = 0; i < SKIP_NUM; i++) drive_beat(K_MID, rnd128(), 0);
    for (int i = 0; i < 2; i++) begin
      d = rnd128(); exp_q.push_back({wb, 5'(i), d}); drive_beat(K_MID, d, 0);
    end
    #2 rst_n = 1'b0;
    m_bank = '0; m_seq = '0; m_cnt = 0; m_finish = 1'b0; m_good = 0; m_errs = 0;
    @(negedge clk);
    n_cmp++; if (out_phu_active_bank !== '0 || out_phu_pkt_hdr_seq !== 8'd0 || out_phu_hdr_cnt !== '0 || out_phu_update_finish !== 1'b0 || out_phu_pkt_hdr_wr !== 1'b0) begin n_fail++; $display("FAIL rstmid_outputs: got bank=%0d seq=%h cnt=%0d finish=%b wr=%b, required all 0", out_phu_active_bank, out_phu_pkt_hdr_seq, out_phu_hdr_cnt, out_phu_update_finish, out_phu_pkt_hdr_wr); end
    n_cmp++; if (out_phu_good_cnt !== 16'd0 || out_phu_err_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid_stats: got %0d %0d, required 0 0", out_phu_good_cnt, out_phu_err_cnt); end
    rst_n = 1'b1;
    @(negedge clk);
    send_pkt(1'b1, 2, 8'h66, 0);   // must land at 32, 33
    n_cmp++; if (out_phu_active_bank !== 1'b1 || out_phu_pkt_hdr_seq !== 8'h66 || out_phu_hdr_cnt !== 6'd2) begin n_fail++; $display("FAIL rstmid_after: got bank=%0d seq=%h cnt=%0d, required 1 66 2", out_phu_active_bank, out_phu_pkt_hdr_seq, out_phu_hdr_cnt); end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_good();
    test_gaps();
    test_bad_type();
    test_overflow();
    test_head_in_load();
    test_lau();
    test_truncated();
    test_random();
    test_stats();
    test_reset_mid();
    test_stats();
    repeat (3) @(negedge clk);
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL missing_writes: got %0d outstanding, required 0", exp_q.size()); end
    n_cmp++; if (obs_pulses !== exp_pulses) begin n_fail++; $display("FAIL total_err: got %0d pulses, required %0d", obs_pulses, exp_pulses); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
